// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register behind the ALU: valid/ready handshake with a
// two-entry skid buffer, branch resolution at capture, flush support.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_alu,
  input  logic          i_zf,
  input  logic [RW-1:0] i_wreg,
  input  logic          i_regwrite,
  input  logic          i_memread,
  input  logic          i_memwrite,
  input  logic          i_beq,
  input  logic          i_bne,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_alu,
  output logic          o_zf,
  output logic [RW-1:0] o_wreg,
  output logic          o_regwrite,
  output logic          o_memread,
  output logic          o_memwrite,
  output logic          o_br_taken,
  output logic [1:0]    o_count
);

  typedef struct packed {
    logic [DW-1:0] alu;
    logic          zf;
    logic [RW-1:0] wreg;
    logic          rw;
    logic          mr;
    logic          mw;
    logic          br;
  } entry_t;

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state_q;
  entry_t main_q, skid_q, new_e;
  logic   ready_q;
  logic   in_x, out_x;

  always_comb begin
    new_e      = '0;
    new_e.alu  = i_alu;
    new_e.zf   = i_zf;
    new_e.wreg = i_wreg;
    new_e.rw   = i_regwrite;
    new_e.mr   = i_memread;
    new_e.mw   = i_memwrite;
    new_e.br   = (i_beq & i_zf) | (i_bne & ~i_zf);
  end

  assign o_valid = (state_q != EMPTY);
  assign in_x    = i_valid & ready_q;
  assign out_x   = o_valid & i_ready;

  // ready_q tracks "next state is not FULL" so it never depends on i_ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (i_flush) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (in_x) begin
          main_q  <= new_e;
          state_q <= ONE;
        end
        ONE: begin
          if (in_x && out_x) begin
            main_q <= new_e;
          end else if (in_x) begin
            skid_q  <= new_e;
            state_q <= FULL;
            ready_q <= 1'b0;
          end else if (out_x) begin
            state_q <= EMPTY;
          end
        end
        FULL: if (out_x) begin
          main_q  <= skid_q;
          state_q <= ONE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_count    = state_q;
  assign o_alu      = main_q.alu;
  assign o_zf       = main_q.zf;
  assign o_wreg     = main_q.wreg;
  assign o_regwrite = o_valid & main_q.rw;
  assign o_memread  = o_valid & main_q.mr;
  assign o_memwrite = o_valid & main_q.mw;
  assign o_br_taken = o_valid & main_q.br;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage with hand-computed expectations.
module tb_ex_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_flush, i_valid, i_ready;
  logic [DW-1:0] i_alu;
  logic          i_zf, i_regwrite, i_memread, i_memwrite, i_beq, i_bne;
  logic [RW-1:0] i_wreg;
  logic          o_ready, o_valid, o_zf, o_regwrite, o_memread, o_memwrite, o_br_taken;
  logic [DW-1:0] o_alu;
  logic [RW-1:0] o_wreg;
  logic [1:0]    o_count;

  int checks = 0;
  int failures = 0;

  ex_mem_stage #(.DW(DW), .RW(RW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_alu(i_alu), .i_zf(i_zf), .i_wreg(i_wreg),
    .i_regwrite(i_regwrite), .i_memread(i_memread), .i_memwrite(i_memwrite),
    .i_beq(i_beq), .i_bne(i_bne),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_alu(o_alu), .o_zf(o_zf), .o_wreg(o_wreg),
    .o_regwrite(o_regwrite), .o_memread(o_memread), .o_memwrite(o_memwrite),
    .o_br_taken(o_br_taken), .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [DW-1:0] a);
    i_valid = v;
    i_alu   = a;
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    i_alu = '0; i_zf = 1'b0; i_wreg = '0;
    i_regwrite = 1'b0; i_memread = 1'b0; i_memwrite = 1'b0;
    i_beq = 1'b0; i_bne = 1'b0;
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_count", o_count, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_alu", o_alu, 0);
    chk("rst_wreg", o_wreg, 0);
    chk("rst_regwrite", o_regwrite, 0);
    chk("rst_br", o_br_taken, 0);
    i_rst_n = 1'b1;

    // Streaming 1..4 with i_ready high
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer(1'b1, k);
      step();
      chk($sformatf("stream_alu%0d", k), o_alu, k);
      chk($sformatf("stream_cnt%0d", k), o_count, 1);
      chk($sformatf("stream_vld%0d", k), o_valid, 1);
    end
    offer(1'b0, 0);
    step();
    chk("stream_drain_cnt", o_count, 0);
    chk("stream_drain_vld", o_valid, 0);

    // Back-pressure: A, B fill the buffer; C refused while full
    i_ready = 1'b0;
    offer(1'b1, 32'hA); i_regwrite = 1'b1; i_memread = 1'b1; i_wreg = 5'd7;
    step();
    chk("bp_a_cnt", o_count, 1);
    chk("bp_a_rdy", o_ready, 1);
    chk("bp_a_regwrite", o_regwrite, 1);
    chk("bp_a_memread", o_memread, 1);
    chk("bp_a_wreg", o_wreg, 7);
    offer(1'b1, 32'hB); i_regwrite = 1'b0; i_memread = 1'b0; i_memwrite = 1'b1; i_wreg = 5'd9;
    step();
    chk("bp_full_cnt", o_count, 2);
    chk("bp_full_rdy", o_ready, 0);
    chk("bp_full_alu", o_alu, 32'hA);
    offer(1'b1, 32'hC); i_memwrite = 1'b0; i_wreg = 5'd3;
    step();
    chk("bp_hold_cnt", o_count, 2);
    chk("bp_hold_alu", o_alu, 32'hA);
    chk("bp_hold_wreg", o_wreg, 7);
    chk("bp_hold_regwrite", o_regwrite, 1);
    i_ready = 1'b1;
    step();
    chk("bp_out_b", o_alu, 32'hB);
    chk("bp_out_b_cnt", o_count, 1);
    chk("bp_out_b_rdy", o_ready, 1);
    chk("bp_out_b_memwrite", o_memwrite, 1);
    chk("bp_out_b_wreg", o_wreg, 9);
    step();
    chk("bp_out_c", o_alu, 32'hC);
    chk("bp_out_c_cnt", o_count, 1);
    chk("bp_out_c_memwrite", o_memwrite, 0);
    offer(1'b0, 0);
    step();
    chk("bp_empty_cnt", o_count, 0);

    // Branch resolution
    offer(1'b1, 32'h1); i_beq = 1'b1; i_zf = 1'b1;
    step();
    chk("br_beq_z", o_br_taken, 1);
    chk("br_beq_zf", o_zf, 1);
    i_beq = 1'b0; i_bne = 1'b1; i_zf = 1'b1;
    step();
    chk("br_bne_z", o_br_taken, 0);
    i_zf = 1'b0;
    step();
    chk("br_bne_nz", o_br_taken, 1);
    i_bne = 1'b0; i_beq = 1'b1; i_zf = 1'b0;
    step();
    chk("br_beq_nz", o_br_taken, 0);
    i_beq = 1'b0; i_bne = 1'b1; i_zf = 1'b0;
    step();
    offer(1'b0, 0);
    step();
    chk("br_gated", o_br_taken, 0);
    i_bne = 1'b0;

    // Flush while FULL discards the simultaneous input
    i_ready = 1'b0; i_regwrite = 1'b1;
    offer(1'b1, 32'h77); step();
    offer(1'b1, 32'h78); step();
    chk("fl_full_cnt", o_count, 2);
    i_flush = 1'b1; offer(1'b1, 32'h55); i_ready = 1'b1;
    step();
    chk("fl_vld", o_valid, 0);
    chk("fl_cnt", o_count, 0);
    chk("fl_rdy", o_ready, 1);
    chk("fl_regwrite", o_regwrite, 0);
    i_flush = 1'b0; offer(1'b0, 0);
    step();
    chk("fl_after_vld", o_valid, 0);
    chk("fl_after_cnt", o_count, 0);

    // Simultaneous in/out in ONE
    offer(1'b1, 32'h10); step();
    chk("sim_main", o_alu, 32'h10);
    offer(1'b1, 32'h20); step();
    chk("sim_alu", o_alu, 32'h20);
    chk("sim_cnt", o_count, 1);
    offer(1'b0, 0); step();

    // Reset mid-stream from FULL
    i_ready = 1'b0; i_regwrite = 1'b1;
    offer(1'b1, 32'h31); step();
    offer(1'b1, 32'h32); step();
    chk("mrst_full_cnt", o_count, 2);
    i_rst_n = 1'b0; i_flush = 1'b1;
    step();
    chk("mrst_vld", o_valid, 0);
    chk("mrst_cnt", o_count, 0);
    chk("mrst_rdy", o_ready, 1);
    chk("mrst_regwrite", o_regwrite, 0);
    chk("mrst_alu", o_alu, 0);
    i_rst_n = 1'b1; i_flush = 1'b0; offer(1'b0, 0);
    step();
    chk("mrst_after_cnt", o_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
